altbramfifo_w129_d256: RTL and testbench
========================================

ALTBRAMFIFO_W129_D256 -- requirements
Module: altbramfifo_w129_d256

Interface
REQ-001 The module SHALL have no parameters; width is fixed at 129 bits and depth at 256 entries.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 aclr  input  1  asynchronous, active-high reset.
REQ-004 data  input  129  write data.
REQ-005 wrreq  input  1  write request.
REQ-006 rdreq  input  1  read request; acknowledges and pops the word currently on q.
REQ-007 q  output  129  show-ahead output, the oldest stored word.
REQ-008 empty  output  1  high when 0 words are stored.
REQ-009 full  output  1  high when 256 words are stored.
REQ-010 usedw  output  8  stored-word count modulo 256.

Function
REQ-011 The FIFO SHALL be first-word-fall-through (show-ahead): while empty=0, q SHALL present the oldest stored word without any rdreq.
REQ-012 An accepted write SHALL store data at the tail on the rising edge where wrreq=1 and full=0.
REQ-013 A write with full=1 SHALL be ignored, with no state change, even if rdreq=1 in the same cycle.
REQ-014 An accepted read SHALL occur on the rising edge where rdreq=1 and empty=0; it SHALL remove the head word, and q SHALL show the next word by the following cycle.
REQ-015 A read with empty=1 SHALL be ignored, with no state change.
REQ-016 A write into an empty FIFO SHALL make empty=0 and q=written data after that same rising edge (one-cycle write-to-visible latency).
REQ-017 An accepted read and an accepted write in the same cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-018 A write into an empty FIFO with rdreq=1 in the same cycle SHALL be treated as write-only, because the read is ignored per REQ-015.
REQ-019 The count SHALL be 9 bits internally (range 0..256), with usedw = count[7:0], full = (count==256) and empty = (count==0).
REQ-020 {full,usedw} SHALL equal the exact occupancy; at 256 words, usedw SHALL read 0 with full=1.
REQ-021 All flags and usedw SHALL be registered outputs, with no combinational path from wrreq or rdreq.
REQ-022 The read and write pointers SHALL be 8-bit and SHALL wrap from 255 to 0 with no loss or duplication of data.
REQ-023 Storage SHALL be inferable as a 256x129 simple dual-port RAM, with a bypass/prefetch register providing the show-ahead q.
REQ-024 When empty=1, q SHALL hold its last value; consumers SHALL NOT rely on it.
REQ-025 Data integrity SHALL hold under arbitrary interleavings of wrreq and rdreq at full throughput (1 write plus 1 read per cycle).

Reset
REQ-026 While aclr=1, the module SHALL immediately and asynchronously force empty=1, full=0, usedw=0, both pointers to 0, and q=0.
REQ-027 An assertion of aclr in the middle of operation SHALL discard all stored words.
REQ-028 Requests present during or on the cycle of aclr deassertion SHALL be ignored until the first rising edge with aclr=0.
REQ-029 RAM contents SHALL NOT need clearing on reset.

Verification
REQ-030 Reset, then write 0x1 -> next cycle empty=0, q=0x1, usedw=1; rdreq one cycle -> empty=1, usedw=0.
REQ-031 Write 256 incrementing words -> full=1, usedw=0; a 257th write is ignored; 256 reads return 0..255 in order, then empty=1.
REQ-032 Full FIFO with simultaneous rdreq+wrreq -> read accepted, write dropped, count=255.
REQ-033 Half-full (128 words) with continuous rdreq+wrreq for 1000 cycles -> count stays 128 and output order matches a reference queue across pointer wrap.
REQ-034 aclr pulse with 50 words stored -> empty=1, usedw=0, full=0 immediately without a clock edge; a later write of 0xABC reads back 0xABC.
REQ-035 rdreq on an empty FIFO plus a simultaneous write -> usedw=1 and empty=0 next cycle.

Source files
------------

// File: rtl/altbramfifo_w129_d256.sv
// 256x129 show-ahead FIFO: a write into an empty FIFO is visible on q one edge later; q always shows the oldest word.
// Backpressure: writes are dropped while full and reads are ignored while empty; flags and usedw are registered.
module altbramfifo_w129_d256 (
  input  logic         clock,
  input  logic         aclr,
  input  logic [128:0] data,
  input  logic         wrreq,
  input  logic         rdreq,
  output logic [128:0] q,
  output logic         empty,
  output logic         full,
  output logic [7:0]   usedw
);

  logic [128:0] mem [256];
  logic [7:0]   wr_ptr;
  logic [7:0]   rd_ptr;
  logic [7:0]   rd_ptr_inc;
  logic [8:0]   count;
  logic [8:0]   count_nxt;
  logic [128:0] byp_q;
  logic [128:0] ram_q;
  logic         byp_sel;
  logic         wr_en;
  logic         rd_en;
  logic         load_byp;
  logic         load_ram;

  always_comb begin
    wr_en      = wrreq & ~full;
    rd_en      = rdreq & ~empty;
    rd_ptr_inc = rd_ptr + 8'd1;
    // The next head is the incoming word when the FIFO is (or is about to become) empty;
    // otherwise it is already in the RAM one slot past the current head.
    load_byp   = wr_en & (empty | (rd_en & (count == 9'd1)));
    load_ram   = rd_en & (count > 9'd1);
    count_nxt  = count;
    if (wr_en && !rd_en) begin
      count_nxt = count + 9'd1;
    end else if (rd_en && !wr_en) begin
      count_nxt = count - 9'd1;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr  <= 8'd0;
      rd_ptr  <= 8'd0;
      count   <= 9'd0;
      empty   <= 1'b1;
      full    <= 1'b0;
      byp_q   <= '0;
      byp_sel <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 8'd1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count_nxt;
      empty <= (count_nxt == 9'd0);
      full  <= (count_nxt == 9'd256);
      if (load_byp) begin
        byp_q   <= data;
        byp_sel <= 1'b1;
      end else if (load_ram) begin
        byp_sel <= 1'b0;
      end
    end
  end

  // Read and write addresses never collide on load_ram: the one-word case goes through the bypass.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= data;
    end
    if (load_ram) begin
      ram_q <= mem[rd_ptr_inc];
    end
  end

  assign q     = byp_sel ? byp_q : ram_q;
  assign usedw = count[7:0];

endmodule

// File: tb/tb_altbramfifo_w129_d256.sv
// Bench for the 256x129 show-ahead FIFO: stimulus pushes expected words, a negedge monitor pops on each accepted read.
module tb_altbramfifo_w129_d256;

  logic         clock;
  logic         aclr;
  logic [128:0] data;
  logic         wrreq;
  logic         rdreq;
  logic [128:0] q;
  logic         empty;
  logic         full;
  logic [7:0]   usedw;

  logic [128:0] exp_q[$];
  int           mcnt;
  int           n_chk;
  int           n_fail;

  altbramfifo_w129_d256 dut (
    .clock(clock),
    .aclr (aclr),
    .data (data),
    .wrreq(wrreq),
    .rdreq(rdreq),
    .q    (q),
    .empty(empty),
    .full (full),
    .usedw(usedw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [128:0] mk(input int i);
    return {1'(i), 64'hDEADBEEF_CAFEF00D, 64'(i)};
  endfunction

  // One clock of stimulus, issued just after a rising edge; flags checked against the model afterwards.
  task automatic step(input logic w, input logic [128:0] d, input logic r);
    logic acc_w;
    logic acc_r;
    wrreq = w;
    data  = d;
    rdreq = r;
    acc_w = w && (mcnt < 256);
    acc_r = r && (mcnt > 0);
    if (acc_w) exp_q.push_back(d);
    @(posedge clock);
    #1;
    mcnt = mcnt + int'(acc_w) - int'(acc_r);
    chk("empty_vs_model", {128'd0, empty}, {128'd0, mcnt == 0});
    chk("full_vs_model",  {128'd0, full},  {128'd0, mcnt == 256});
    chk("usedw_vs_model", {121'd0, usedw}, 129'(mcnt % 256));
  endtask

  // Monitor: a read is accepted at the next edge when rdreq=1 and empty=0; q must hold the oldest word.
  always @(negedge clock) begin
    if (!aclr && rdreq && !empty) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: read accepted with got q=%h but expected no word", q);
      end else begin
        chk("sb_q", q, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mcnt   = 0;
    aclr   = 1'b1;
    data   = '0;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    #3;
    chk("rst_empty", {128'd0, empty}, 129'd1);
    chk("rst_full",  {128'd0, full},  129'd0);
    chk("rst_usedw", {121'd0, usedw}, 129'd0);
    chk("rst_q",     q,               129'd0);
    @(posedge clock);
    #1;
    aclr = 1'b0;

    // Single write then read
    step(1'b1, 129'h1, 1'b0);
    chk("w1_empty", {128'd0, empty}, 129'd0);
    chk("w1_q",     q,               129'h1);
    chk("w1_usedw", {121'd0, usedw}, 129'd1);
    step(1'b0, '0, 1'b1);
    chk("r1_empty", {128'd0, empty}, 129'd1);
    chk("r1_usedw", {121'd0, usedw}, 129'd0);

    // Fill to 256, overflow write, drain in order
    for (int i = 0; i < 256; i++) step(1'b1, 129'(i), 1'b0);
    chk("fill_full",  {128'd0, full},  129'd1);
    chk("fill_usedw", {121'd0, usedw}, 129'd0);
    chk("fill_q",     q,               129'd0);
    step(1'b1, 129'h3E7, 1'b0);
    chk("ovf_full",  {128'd0, full},  129'd1);
    chk("ovf_usedw", {121'd0, usedw}, 129'd0);
    for (int i = 0; i < 256; i++) step(1'b0, '0, 1'b1);
    chk("drain_empty", {128'd0, empty}, 129'd1);

    // Full with simultaneous read and write: write dropped
    for (int i = 0; i < 256; i++) step(1'b1, mk(32'h1000 + i), 1'b0);
    step(1'b1, 129'hDEAD, 1'b1);
    chk("fullrw_full",  {128'd0, full},  129'd0);
    chk("fullrw_usedw", {121'd0, usedw}, 129'd255);
    chk("fullrw_q",     q,               mk(32'h1001));
    for (int i = 0; i < 255; i++) step(1'b0, '0, 1'b1);
    chk("fullrw_drained", {128'd0, empty}, 129'd1);

    // Half full, 1000 cycles of read+write across pointer wrap
    for (int i = 0; i < 128; i++) step(1'b1, mk(32'h20000 + i), 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b1, mk(32'h30000 + i), 1'b1);
    chk("half_usedw", {121'd0, usedw}, 129'd128);
    for (int i = 0; i < 128; i++) step(1'b0, '0, 1'b1);
    chk("half_drained", {128'd0, empty}, 129'd1);

    // Read on empty with simultaneous write behaves as write-only
    step(1'b1, 129'h55, 1'b1);
    chk("erw_usedw", {121'd0, usedw}, 129'd1);
    chk("erw_empty", {128'd0, empty}, 129'd0);
    chk("erw_q",     q,               129'h55);
    step(1'b0, '0, 1'b1);

    // Asynchronous clear mid-operation with 50 words stored
    for (int i = 0; i < 50; i++) step(1'b1, mk(32'h40000 + i), 1'b0);
    aclr  = 1'b1;
    wrreq = 1'b1;
    rdreq = 1'b1;
    data  = 129'h777;
    #2;
    chk("aclr_empty", {128'd0, empty}, 129'd1);
    chk("aclr_usedw", {121'd0, usedw}, 129'd0);
    chk("aclr_full",  {128'd0, full},  129'd0);
    chk("aclr_q",     q,               129'd0);
    exp_q.delete();
    mcnt = 0;
    @(posedge clock);
    #1;
    chk("aclr_hold_empty", {128'd0, empty}, 129'd1);
    aclr  = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    @(posedge clock);
    #1;
    chk("post_aclr_empty", {128'd0, empty}, 129'd1);
    step(1'b1, 129'hABC, 1'b0);
    chk("post_aclr_q", q, 129'hABC);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    chk("sb_drained", 129'(exp_q.size()), 129'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
